otp_xor_sequencer: RTL and testbench
====================================

Name: otp_xor_sequencer

Overview:
Sequences one-time-pad encryption of a byte stream. It shares a single byte-to-word packer between two requesters, the plaintext byte source and the key-pad byte source. It assembles one 32-bit plaintext word, then one 32-bit key word, XORs them and presents the ciphertext word downstream over a valid/ready handshake. It enforces single use of key material with a key-word budget.

Parameters:
KEY_WORDS, 16, number of key words available before the pad is exhausted (range 1..65535).
BYTES_PER_WORD, 4, bytes per packed word (fixed at 4; not for override).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
pt_byte  input  8  plaintext byte.
pt_valid  input  1  plaintext byte available.
pt_ready  output  1  plaintext byte accepted this cycle when pt_valid=1.
key_byte  input  8  key-pad byte.
key_valid  input  1  key byte available.
key_ready  output  1  key byte accepted this cycle when key_valid=1.
ct_data  output  32  ciphertext word (pt_word XOR key_word).
ct_valid  output  1  ct_data is valid.
ct_ready  input  1  downstream accepts ct_data.
key_exhausted  output  1  sticky; the pad budget is used up.
words_done  output  16  count of ciphertext words accepted downstream.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. All state is updated on the rising edge of clk only.
- Reset values:
  - state=LOAD_PT, byte index=0.
  - pt_word=0, key_word=0.
  - ct_data=0, ct_valid=0, pt_ready=0, key_ready=0.
  - key_exhausted=0, words_done=0, internal key counter=0.
- Byte order: the first byte accepted goes to [31:24], then [23:16], [15:8], [7:0].
- States:
  - LOAD_PT: pt_ready=1, key_ready=0. Each cycle with pt_valid=1 stores the byte and increments the index. After the 4th byte: index←0, go to LOAD_KEY.
  - LOAD_KEY: key_ready=1, pt_ready=0. Same packing rule using key_byte. After the 4th byte: ct_data←pt_word^key_word, ct_valid←1, key counter+1, go to EMIT.
  - EMIT: pt_ready=key_ready=0, ct_data held stable. On ct_valid&ct_ready: ct_valid←0, words_done+1.
    - If key counter==KEY_WORDS, set key_exhausted, go to HALT.
    - Otherwise go to LOAD_PT.
  - HALT: all ready outputs 0, ct_valid=0. Left only via reset.
- Ready signals are registered functions of state. They must never be 1 in EMIT or HALT. pt_ready and key_ready are never both 1.
- Gaps: no byte is consumed on a cycle when the selected valid is 0; the index holds. Bytes offered by the non-selected source are ignored and not consumed.
- Latency:
  - Minimum 8 cycles from the first plaintext byte to ct_valid.
  - Minimum 9 cycles per word with ct_ready held high, since EMIT costs at least 1 cycle.
- words_done wraps at 16 bits. The key counter saturates at KEY_WORDS.
- Reset mid-word discards partial words. No partial ciphertext is ever emitted.
- Once key_exhausted=1 it stays 1 until reset.

Optional Feature:
OTP_KEY_ZEROIZE_EN.
- Defined: on the EMIT handshake (ct_valid&ct_ready), key_word and pt_word are cleared to 0 in the same edge, and ct_data is cleared to 0 one cycle later. No key or plaintext residue remains in registers.
- Undefined: these registers retain their last values until overwritten.
- Externally visible handshake timing is identical in both builds.

Decomposition:
- Package otp_pkg:
  - state encoding LOAD_PT=2'd0, LOAD_KEY=2'd1, EMIT=2'd2, HALT=2'd3.
  - BYTES_PER_WORD=4.
  - byte index width 2.
  - counter width 16.
- Sub-module byte_word_packer:
  - inputs clk, reset, clear, load, byte_in.
  - outputs word_out[31:0], full (pulses on the 4th load).
  - The sequencer instantiates it once and shares it; it muxes byte_in and latches word_out into pt_word or key_word depending on state.

Test Plan:
- Plaintext 0x11,0x22,0x33,0x44 then key 0xFF,0x00,0xF0,0x0F, ct_ready=1 → ct_data=0xEE22C34B, ct_valid=1 for exactly 1 cycle, words_done=1.
- key_valid=1 with key bytes offered during LOAD_PT → key_ready=0, no key byte consumed; the plaintext word completes first.
- ct_ready=0 for 5 cycles in EMIT → ct_data stable, ct_valid=1, pt_ready=key_ready=0 throughout; words_done increments once on release.
- KEY_WORDS=2, send 3 word pairs → after the 2nd handshake key_exhausted=1, state HALT, pt_ready stays 0, words_done=2.
- Reset asserted after 2 plaintext bytes → next word uses 4 fresh bytes; the output equals the XOR of only the post-reset bytes.
- With OTP_KEY_ZEROIZE_EN: one cycle after the handshake, internal key_word=0 and ct_data=0; without the macro, ct_data retains its value.

Source files
------------

// File: rtl/otp_xor_sequencer_pkg.sv
// Shared types and constants for the one-time-pad XOR sequencer.
package otp_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    LOAD_PT  = 2'd0,
    LOAD_KEY = 2'd1,
    EMIT     = 2'd2,
    HALT     = 2'd3
  } state_t;

endpackage

// File: rtl/otp_xor_sequencer_if.sv
// Byte-in / word-out stream bundle: plaintext and key byte sources plus ciphertext sink.
interface otp_xor_sequencer_if;
  logic [7:0]  pt_byte;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  key_byte;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] ct_data;
  logic        ct_valid;
  logic        ct_ready;

  modport master (
    output pt_byte, pt_valid, key_byte, key_valid, ct_ready,
    input  pt_ready, key_ready, ct_data, ct_valid
  );

  modport slave (
    input  pt_byte, pt_valid, key_byte, key_valid, ct_ready,
    output pt_ready, key_ready, ct_data, ct_valid
  );
endinterface

// File: rtl/otp_xor_sequencer_byte_word_packer.sv
// Packs four bytes MSB-first into a 32-bit word; word_out already includes the byte loaded this cycle.
module byte_word_packer
  import otp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        full
);

  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      word_reg;

  // Lane gi holds the gi-th accepted byte, so lane 0 lands in [31:24].
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word_out[31-8*gi -: 8] = (load && (idx_reg == IDX_W'(gi))) ? byte_in
                                                                       : word_reg[31-8*gi -: 8];
    end
  endgenerate

  assign full = load && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_reg  <= '0;
      word_reg <= '0;
    end else if (load) begin
      if (full) begin
        idx_reg  <= '0;
        word_reg <= '0;
      end else begin
        idx_reg  <= idx_reg + IDX_W'(1);
        word_reg <= word_out;
      end
    end
  end

endmodule

// File: rtl/otp_xor_sequencer.sv
// One-time-pad sequencer: plaintext word, then key word, XOR, emit; halts when the key budget is spent.
// Optional build macro OTP_KEY_ZEROIZE_EN wipes pt/key words and ct_data after each handshake.
module otp_xor_sequencer
  import otp_pkg::*;
#(
  parameter int KEY_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset,
  otp_xor_sequencer_if.slave  otp,
  output logic                key_exhausted,
  output logic [CNT_W-1:0]    words_done
);

  state_t           state_reg, state_next;
  logic             pt_ready_reg, key_ready_reg, ct_valid_reg, key_exhausted_reg;
  logic [31:0]      pt_word_reg, key_word_reg, ct_data_reg;
  logic [CNT_W-1:0] key_cnt_reg, words_done_reg;

  logic        pt_take, key_take, ct_fire, budget_spent;
  logic        pack_load, pack_clear, pack_full;
  logic [7:0]  pack_byte;
  logic [31:0] pack_word;

  assign pt_take      = otp.pt_valid && pt_ready_reg;
  assign key_take     = otp.key_valid && key_ready_reg;
  assign ct_fire      = ct_valid_reg && otp.ct_ready;
  assign budget_spent = (key_cnt_reg == CNT_W'(KEY_WORDS));

  // The ready registers are mutually exclusive, so they also select the packer source.
  assign pack_load  = pt_take || key_take;
  assign pack_byte  = key_ready_reg ? otp.key_byte : otp.pt_byte;
  assign pack_clear = (state_reg == EMIT) || (state_reg == HALT);

  byte_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pack_clear),
    .load     (pack_load),
    .byte_in  (pack_byte),
    .word_out (pack_word),
    .full     (pack_full)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD_PT:  if (pack_full) state_next = LOAD_KEY;
      LOAD_KEY: if (pack_full) state_next = EMIT;
      EMIT:     if (ct_fire)   state_next = budget_spent ? HALT : LOAD_PT;
      default:  state_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= LOAD_PT;
      pt_ready_reg  <= 1'b0;
      key_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pt_ready_reg  <= (state_next == LOAD_PT);
      key_ready_reg <= (state_next == LOAD_KEY);
    end
  end

`ifdef OTP_KEY_ZEROIZE_EN
  logic zeroize_pending_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pt_word_reg       <= '0;
      key_word_reg      <= '0;
      ct_data_reg       <= '0;
      ct_valid_reg      <= 1'b0;
      key_cnt_reg       <= '0;
      words_done_reg    <= '0;
      key_exhausted_reg <= 1'b0;
`ifdef OTP_KEY_ZEROIZE_EN
      zeroize_pending_reg <= 1'b0;
`endif
    end else begin
      if ((state_reg == LOAD_PT) && pack_full) begin
        pt_word_reg <= pack_word;
      end
      if ((state_reg == LOAD_KEY) && pack_full) begin
        key_word_reg <= pack_word;
        ct_data_reg  <= pt_word_reg ^ pack_word;
        ct_valid_reg <= 1'b1;
        if (!budget_spent) key_cnt_reg <= key_cnt_reg + CNT_W'(1);
      end
      if (ct_fire) begin
        ct_valid_reg   <= 1'b0;
        words_done_reg <= words_done_reg + CNT_W'(1);
        if (budget_spent) key_exhausted_reg <= 1'b1;
`ifdef OTP_KEY_ZEROIZE_EN
        pt_word_reg  <= '0;
        key_word_reg <= '0;
`endif
      end
`ifdef OTP_KEY_ZEROIZE_EN
      // ct_data is wiped one edge after the handshake that consumed it.
      zeroize_pending_reg <= ct_fire;
      if (zeroize_pending_reg) ct_data_reg <= '0;
`endif
    end
  end

  assign otp.pt_ready   = pt_ready_reg;
  assign otp.key_ready  = key_ready_reg;
  assign otp.ct_data    = ct_data_reg;
  assign otp.ct_valid   = ct_valid_reg;
  assign key_exhausted  = key_exhausted_reg;
  assign words_done     = words_done_reg;

endmodule

// File: tb/tb_otp_xor_sequencer.sv
// Scoreboard bench for otp_xor_sequencer built with a two-word key budget.
module tb_otp_xor_sequencer;
  import otp_pkg::*;

  logic        clk;
  logic        reset;
  logic        key_exhausted;
  logic [15:0] words_done;

  otp_xor_sequencer_if bus ();

  otp_xor_sequencer #(.KEY_WORDS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .otp           (bus),
    .key_exhausted (key_exhausted),
    .words_done    (words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic apply_reset();
    @(negedge clk);
    bus.pt_valid = 1'b0; bus.key_valid = 1'b0; bus.ct_ready = 1'b0;
    bus.pt_byte = 8'h00; bus.key_byte = 8'h00;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Offers one byte and waits (bounded) until it is accepted; cycles counts elapsed negedges.
  task automatic drive_byte(input bit is_key, input logic [7:0] b, input int bound,
                            output bit ok, output int cycles);
    if (is_key) begin bus.key_byte = b; bus.key_valid = 1'b1; end
    else begin bus.pt_byte = b; bus.pt_valid = 1'b1; end
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < bound) begin
      if ((is_key ? bus.key_ready : bus.pt_ready) === 1'b1) ok = 1'b1;
      @(negedge clk);
      cycles++;
    end
    if (is_key) bus.key_valid = 1'b0; else bus.pt_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] pt, input logic [31:0] key, input int bound,
                           output bit ok, output int cycles);
    bit b_ok;
    int c;
    ok = 1'b1;
    cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (ok) begin drive_byte(1'b0, pt[31-8*i -: 8], bound, b_ok, c); cycles += c; ok &= b_ok; end
    end
    for (int i = 0; i < 4; i++) begin
      if (ok) begin drive_byte(1'b1, key[31-8*i -: 8], bound, b_ok, c); cycles += c; ok &= b_ok; end
    end
    if (ok) exp_q.push_back(pt ^ key);
  endtask

  task automatic wait_ct(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (bus.ct_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_basic();
    bit ok; int cyc; logic [31:0] exp;
    apply_reset();
    bus.ct_ready = 1'b1;
    send_word(32'h11223344, 32'hFF00F00F, 50, ok, cyc);
    checks++; if (!ok || cyc !== 8) begin errors++; $display("FAIL basic_latency: cycles=%0d ok=%0b required 8", cyc, ok); end
    wait_ct(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: ct_valid=%b required 1", bus.ct_valid); end
    else begin
      exp = exp_q.pop_front();
      $display("basic: ct_data=%08h expected=%08h", bus.ct_data, exp);
      checks++; if (bus.ct_data !== 32'hEE22C34B || exp !== 32'hEE22C34B) begin errors++; $display("FAIL basic_data: got=%08h required=%08h", bus.ct_data, 32'hEE22C34B); end
      checks++; if ({bus.pt_ready, bus.key_ready} !== 2'b00) begin errors++; $display("FAIL basic_emit_ready: got=%b required 00", {bus.pt_ready, bus.key_ready}); end
    end
    @(negedge clk);
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got=%b required 0", bus.ct_valid); end
    checks++; if (words_done !== 16'd1) begin errors++; $display("FAIL basic_words_done: got=%0d required 1", words_done); end
    checks++; if (bus.pt_ready !== 1'b1) begin errors++; $display("FAIL basic_back_to_pt: got=%b required 1", bus.pt_ready); end
  endtask

  task automatic test_ignore_key();
    bit ok; int c; logic [31:0] exp;
    logic [31:0] pt  = 32'hCAFEBABE;
    logic [31:0] key = 32'h01234567;
    apply_reset();
    bus.ct_ready = 1'b1;
    bus.key_byte = 8'hAA;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL ignore_key_ready%0d: got=%b required 0", i, bus.key_ready); end
      drive_byte(1'b0, pt[31-8*i -: 8], 50, ok, c);
    end
    for (int i = 0; i < 4; i++) drive_byte(1'b1, key[31-8*i -: 8], 50, ok, c);
    exp_q.push_back(pt ^ key);
    wait_ct(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_key_timeout: ct_valid=%b required 1", bus.ct_valid); end
    else begin
      exp = exp_q.pop_front();
      $display("ignore_key: ct_data=%08h expected=%08h", bus.ct_data, exp);
      checks++; if (bus.ct_data !== exp) begin errors++; $display("FAIL ignore_key_data: got=%08h required=%08h", bus.ct_data, exp); end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int cyc; logic [31:0] exp;
    apply_reset();
    bus.ct_ready = 1'b0;
    send_word(32'h5A5A0F0F, 32'h0FF0A55A, 50, ok, cyc);
    wait_ct(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: ct_valid=%b required 1", bus.ct_valid); end
    else begin
      exp = exp_q.pop_front();
      $display("backpressure: ct_data=%08h expected=%08h", bus.ct_data, exp);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (bus.ct_data !== exp || bus.ct_valid !== 1'b1 || bus.pt_ready !== 1'b0 ||
            bus.key_ready !== 1'b0 || words_done !== 16'd0) begin
          errors++;
          $display("FAIL bp_hold%0d: data=%08h v=%b pr=%b kr=%b wd=%0d required data=%08h v=1 pr=0 kr=0 wd=0",
                   i, bus.ct_data, bus.ct_valid, bus.pt_ready, bus.key_ready, words_done, exp);
        end
        @(negedge clk);
      end
      bus.ct_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.ct_valid !== 1'b0 || words_done !== 16'd1) begin errors++; $display("FAIL bp_release: v=%b wd=%0d required v=0 wd=1", bus.ct_valid, words_done); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; logic [31:0] exp;
    apply_reset();
    bus.ct_ready = 1'b1;
    send_word(32'h00000001, 32'h80000000, 50, ok, cyc);
    wait_ct(ok);
    exp = exp_q.pop_front();
    $display("b2b word0: ct_data=%08h expected=%08h", bus.ct_data, exp);
    checks++; if (!ok || bus.ct_data !== exp) begin errors++; $display("FAIL b2b_data0: got=%08h required=%08h", bus.ct_data, exp); end
    send_word(32'h12345678, 32'hFFFFFFFF, 50, ok, cyc);
    checks++; if (!ok || cyc !== 9) begin errors++; $display("FAIL b2b_period: cycles=%0d ok=%0b required 9", cyc, ok); end
    wait_ct(ok);
    exp = exp_q.pop_front();
    $display("b2b word1: ct_data=%08h expected=%08h", bus.ct_data, exp);
    checks++; if (!ok || bus.ct_data !== exp) begin errors++; $display("FAIL b2b_data1: got=%08h required=%08h", bus.ct_data, exp); end
    @(negedge clk);
    checks++; if (words_done !== 16'd2 || key_exhausted !== 1'b1) begin errors++; $display("FAIL b2b_end: wd=%0d ke=%b required wd=2 ke=1", words_done, key_exhausted); end
  endtask

  task automatic test_exhaust();
    bit ok; int cyc; logic [31:0] exp;
    apply_reset();
    bus.ct_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      send_word(32'hA0B0C0D0 + w, 32'h0F0F0F0F, 50, ok, cyc);
      wait_ct(ok);
      exp = exp_q.pop_front();
      $display("exhaust word%0d: ct_data=%08h expected=%08h", w, bus.ct_data, exp);
      checks++; if (!ok || bus.ct_data !== exp) begin errors++; $display("FAIL exhaust_data%0d: got=%08h required=%08h", w, bus.ct_data, exp); end
      @(negedge clk);
      checks++; if (key_exhausted !== (w == 1)) begin errors++; $display("FAIL exhaust_flag%0d: got=%b required=%b", w, key_exhausted, (w == 1)); end
    end
    checks++; if (dut.state_reg !== HALT || bus.pt_ready !== 1'b0) begin errors++; $display("FAIL exhaust_halt: state=%0d pr=%b required state=3 pr=0", dut.state_reg, bus.pt_ready); end
    drive_byte(1'b0, 8'h77, 20, ok, cyc);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL exhaust_pt_blocked: accepted=%b required 0", ok); end
    checks++;
    if (key_exhausted !== 1'b1 || words_done !== 16'd2 || bus.ct_valid !== 1'b0 || bus.key_ready !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_sticky: ke=%b wd=%0d v=%b kr=%b required ke=1 wd=2 v=0 kr=0", key_exhausted, words_done, bus.ct_valid, bus.key_ready);
    end
  endtask

  // Follows test_exhaust so that the flag, counters and state start out non-zero.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({bus.pt_ready, bus.key_ready, bus.ct_valid} !== 3'b000) begin errors++; $display("FAIL reset_ready_valid: got=%b required 000", {bus.pt_ready, bus.key_ready, bus.ct_valid}); end
    checks++; if (bus.ct_data !== 32'h0) begin errors++; $display("FAIL reset_ct_data: got=%08h required 00000000", bus.ct_data); end
    checks++; if (key_exhausted !== 1'b0 || words_done !== 16'd0) begin errors++; $display("FAIL reset_status: ke=%b wd=%0d required ke=0 wd=0", key_exhausted, words_done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.pt_ready !== 1'b1 || bus.key_ready !== 1'b0 || dut.state_reg !== LOAD_PT) begin errors++; $display("FAIL reset_release: pr=%b kr=%b state=%0d required pr=1 kr=0 state=0", bus.pt_ready, bus.key_ready, dut.state_reg); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; logic [31:0] exp;
    apply_reset();
    bus.ct_ready = 1'b1;
    drive_byte(1'b0, 8'hDE, 50, ok, cyc);
    drive_byte(1'b0, 8'hAD, 50, ok, cyc);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_word(32'h01020304, 32'h10203040, 50, ok, cyc);
    wait_ct(ok);
    exp = exp_q.pop_front();
    $display("reset_mid: ct_data=%08h expected=%08h", bus.ct_data, exp);
    checks++; if (!ok || bus.ct_data !== 32'h11223344) begin errors++; $display("FAIL reset_mid_data: got=%08h required=11223344", bus.ct_data); end
  endtask

  task automatic test_zeroize();
    bit ok; int cyc; logic [31:0] exp;
    apply_reset();
    bus.ct_ready = 1'b1;
    send_word(32'hA5A5A5A5, 32'h3C3C3C3C, 50, ok, cyc);
    wait_ct(ok);
    exp = exp_q.pop_front();
    $display("zeroize: ct_data=%08h expected=%08h", bus.ct_data, exp);
    checks++; if (!ok || bus.ct_data !== 32'h99999999) begin errors++; $display("FAIL zeroize_data: got=%08h required=99999999", bus.ct_data); end
    repeat (2) @(negedge clk);
`ifdef OTP_KEY_ZEROIZE_EN
    checks++; if (bus.ct_data !== 32'h0) begin errors++; $display("FAIL zeroize_ct: got=%08h required 00000000", bus.ct_data); end
    checks++; if (dut.key_word_reg !== 32'h0 || dut.pt_word_reg !== 32'h0) begin errors++; $display("FAIL zeroize_words: key=%08h pt=%08h required 0", dut.key_word_reg, dut.pt_word_reg); end
`else
    checks++; if (bus.ct_data !== 32'h99999999) begin errors++; $display("FAIL retain_ct: got=%08h required=99999999", bus.ct_data); end
    checks++; if (dut.key_word_reg !== 32'h3C3C3C3C) begin errors++; $display("FAIL retain_key: got=%08h required=3c3c3c3c", dut.key_word_reg); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.pt_valid = 1'b0; bus.key_valid = 1'b0; bus.ct_ready = 1'b0;
    bus.pt_byte = 8'h00; bus.key_byte = 8'h00;
    apply_reset();
    test_basic();
    test_ignore_key();
    test_backpressure();
    test_back_to_back();
    test_exhaust();
    test_reset();
    test_reset_mid();
    test_zeroize();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
